// File: rtl/game_binary_entry.sv
// Binary entry game: shows a decimal digit 1..7, the player keys its 3-bit
// binary form MSB first on two buttons, then the block shows correct/error.
module game_binary_entry #(
    parameter int COUNTER_LEN  = 24,
    parameter int DELAY_TIME   = 10_000_000,
    parameter int TIMEOUT_TIME = 16_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn0,
    input  logic       btn1,
    input  logic [3:0] rnd,
    output logic [3:0] value
);

    localparam logic [COUNTER_LEN-1:0] DELAY_CNT   = COUNTER_LEN'(DELAY_TIME);
    localparam logic [COUNTER_LEN-1:0] TIMEOUT_CNT = COUNTER_LEN'(TIMEOUT_TIME);
    localparam logic [COUNTER_LEN-1:0] CNT_ONE     = COUNTER_LEN'(1);

    localparam logic [3:0] V_CORRECT = 4'd10;
    localparam logic [3:0] V_ERROR   = 4'd11;
    localparam logic [3:0] V_BLANK   = 4'd12;
    localparam logic [3:0] V_QUERY   = 4'd13;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_ENTER  = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    state_t                 state;
    logic [COUNTER_LEN-1:0] counter;
    logic [2:0]             target;
    logic [2:0]             entered;
    logic [1:0]             bit_count;
    logic                   prev_btn0;
    logic                   prev_btn1;

    logic       e0;
    logic       e1;
    logic       entry;
    logic       bit_in;
    logic [2:0] next_entered;
    logic [2:0] rnd_target;
    logic       unused_rnd_msb;

    // Simultaneous edges cancel out: only a lone edge counts as an entry.
    always_comb begin
        e0           = btn0 & ~prev_btn0;
        e1           = btn1 & ~prev_btn1;
        entry        = e0 ^ e1;
        bit_in       = e1;
        next_entered = {entered[1:0], bit_in};
        rnd_target   = (rnd[2:0] == 3'd0) ? 3'd5 : rnd[2:0];
    end

    assign unused_rnd_msb = rnd[3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_WAIT;
            value     <= V_BLANK;
            counter   <= '0;
            target    <= 3'd1;
            entered   <= '0;
            bit_count <= '0;
            prev_btn0 <= 1'b1;
            prev_btn1 <= 1'b1;
        end else begin
            prev_btn0 <= btn0;
            prev_btn1 <= btn1;
            case (state)
                ST_WAIT: begin
                    value   <= V_BLANK;
                    counter <= '0;
                    if (e0 | e1) begin
                        target <= rnd_target;
                        value  <= {1'b0, rnd_target};
                        state  <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (counter >= DELAY_CNT) begin
                        counter   <= '0;
                        bit_count <= '0;
                        entered   <= '0;
                        value     <= V_QUERY;
                        state     <= ST_ENTER;
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end
                ST_ENTER: begin
                    if (entry) begin
                        entered   <= next_entered;
                        bit_count <= bit_count + 2'd1;
                        counter   <= '0;
                        // The third bit goes straight to the verdict; its echo is never shown.
                        if (bit_count == 2'd2) begin
                            state <= ST_RESULT;
                            value <= (next_entered == target) ? V_CORRECT : V_ERROR;
                        end else begin
                            value <= {3'b000, bit_in};
                        end
                    end else if (counter >= TIMEOUT_CNT) begin
                        state   <= ST_RESULT;
                        value   <= V_ERROR;
                        counter <= '0;
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end
                ST_RESULT: begin
                    if (counter >= DELAY_CNT) begin
                        counter <= '0;
                        value   <= V_BLANK;
                        state   <= ST_WAIT;
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end
                default: begin
                    state   <= ST_WAIT;
                    value   <= V_BLANK;
                    counter <= '0;
                end
            endcase
        end
    end

endmodule
